// File: rtl/i2c_bit_phy.sv
// Bit-level I2C master line driver: runs one START/DATA/ACK/STOP slot per
// accepted command, 4*DIV cycles each, and returns the sampled ACK level.
module i2c_bit_phy #(
  parameter int DIV = 250
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd,
  input  logic       cmd_bit,
  input  logic       sda_in,
  output logic       scl_out,
  output logic       sda_oe,
  output logic       ack_n,
  output logic       ack_valid,
  output logic       bit_done,
  output logic       busy
);
  localparam int CW = $clog2(DIV);
  localparam logic [1:0] C_DATA  = 2'd0;
  localparam logic [1:0] C_START = 2'd1;
  localparam logic [1:0] C_STOP  = 2'd2;
  localparam logic [1:0] C_ACK   = 2'd3;

  typedef enum logic [1:0] {IDLE, HOLD, RUN} state_t;

  state_t        state;
  logic [1:0]    phase;
  logic [CW-1:0] cnt;
  logic [1:0]    cmd_q;
  logic          bit_q;
  logic          q_last;
  logic          q_prelast;

  assign q_last    = (cnt == CW'(DIV - 1));
  assign q_prelast = (cnt == CW'(DIV - 2));
  assign busy      = (state == RUN);
  assign cmd_ready = (state != RUN) && !reset;

  // Line levels {scl, sda_oe} for a given phase; phase 0 may hold prior levels.
  function automatic logic [1:0] levels(input logic [1:0] c, input logic b,
                                        input logic [1:0] ph, input logic scl0,
                                        input logic oe0);
    logic s, o;
    s = scl0;
    o = oe0;
    case (c)
      C_DATA: begin
        s = ph[1];
        o = (ph == 2'd0) ? oe0 : ~b;
      end
      C_ACK: begin
        s = ph[1];
        o = (ph == 2'd0) ? oe0 : 1'b0;
      end
      C_START: begin
        s = (ph == 2'd0) ? scl0 : 1'b1;
        o = ph[1];
      end
      default: begin
        s = (ph != 2'd0);
        o = (ph != 2'd3);
      end
    endcase
    return {s, o};
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      phase     <= 2'd0;
      cnt       <= '0;
      cmd_q     <= 2'd0;
      bit_q     <= 1'b0;
      scl_out   <= 1'b1;
      sda_oe    <= 1'b0;
      ack_n     <= 1'b1;
      ack_valid <= 1'b0;
      bit_done  <= 1'b0;
    end else begin
      ack_valid <= 1'b0;
      bit_done  <= 1'b0;
      case (state)
        IDLE, HOLD: begin
          if (cmd_valid) begin
            state               <= RUN;
            phase               <= 2'd0;
            cnt                 <= '0;
            cmd_q               <= cmd;
            bit_q               <= cmd_bit;
            {scl_out, sda_oe}   <= levels(cmd, cmd_bit, 2'd0, scl_out, sda_oe);
          end
        end
        RUN: begin
          cnt <= q_last ? '0 : cnt + CW'(1);
          if (phase == 2'd3 && q_prelast) bit_done <= 1'b1;
          // ACK level is taken on the edge that enters phase 3
          if (phase == 2'd2 && q_last && cmd_q == C_ACK) begin
            ack_n     <= sda_in;
            ack_valid <= 1'b1;
          end
          if (q_last) begin
            if (phase == 2'd3) begin
              phase <= 2'd0;
              if (cmd_q == C_STOP) begin
                state   <= IDLE;
                scl_out <= 1'b1;
                sda_oe  <= 1'b0;
              end else begin
                state   <= HOLD;
                scl_out <= 1'b0;
              end
            end else begin
              phase             <= phase + 2'd1;
              {scl_out, sda_oe} <= levels(cmd_q, bit_q, phase + 2'd1, scl_out, sda_oe);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
